multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS datapath. It decodes the latched instruction into an instruction class and steps it through IF/DCD/EXE/MEM/WB. Each cycle it drives the write enables and mux selects the single-cycle decoder drives. It sits beside the multi-cycle datapath (PC, IR, register file, ALU, shared memory port) and waits on that memory port's ready signal.

## Interface
Parameters: none.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state to IF
- opcode  in  6  IR[31:26], stable from DCD onward (IR written by IRWr)
- funct  in  6  IR[5:0]
- zero  in  1  ALU equal flag, valid in EXE
- mem_ready  in  1  memory port completes access this cycle
- PCWr  out  1  PC load enable
- IRWr  out  1  IR load enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- RegSrc  out  2  00 ALU, 01 memory, 10 PC
- ALUSrc  out  1  0 rt data, 1 extended immediate
- ExtOp  out  1  0 zero-extend, 1 sign-extend
- ALUCtrl  out  3  000 add, 001 sub, 010 or, 011 lui (B<<16)
- nPC_sel  out  2  00 PC+4, 01 branch, 10 j-target, 11 rs
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state  out  3  current state, for debug

## Operation
- Supported: addu, subu, jr (R-type, funct 100001/100011/001000); ori, lw, sw, beq, lui, jal. Any other opcode or funct is a nop.
- States: IF=0, DCD=1, EXE=2, MEM=3, WB=4. The 3-bit register is the only state.
- IF: IRWr=1, nPC_sel=00. PCWr=mem_ready. Stays in IF while mem_ready=0, otherwise goes to DCD.
- DCD, jal: PCWr=1, nPC_sel=10, RegWrite=1, RegDst=10, RegSrc=10. RegSrc=10 writes the already-incremented PC (PC+4). Next state IF; instr_done=1.
- DCD, jr: PCWr=1, nPC_sel=11. Next state IF; instr_done=1.
- DCD, nop/unknown: no enables. Next state IF; instr_done=1.
- DCD, all other instructions: next state EXE.
- EXE, beq: ALUCtrl=001, ALUSrc=0, ExtOp=1, nPC_sel=01, PCWr=zero. Next state IF; instr_done=1.
- EXE, lw/sw: ALUCtrl=000, ALUSrc=1, ExtOp=1. Next state MEM.
- EXE, addu/subu: ALUCtrl 000/001, ALUSrc=0. Next state WB.
- EXE, ori/lui: ALUCtrl 010/011, ALUSrc=1, ExtOp=0. Next state WB.
- MEM, sw: MemWrite=1 every cycle in MEM. Holds until mem_ready=1, then goes to IF with instr_done=1.
- MEM, lw: holds until mem_ready=1, then goes to WB.
- WB: RegWrite=1. RegDst=01 for R-type, 00 otherwise. RegSrc=01 for lw, 00 otherwise. Next state IF; instr_done=1.
- ALU/mux selects are held in every state an instruction occupies, so datapath registers see stable inputs.
- All enables are 0 in any state not listed for them.

## Timing
- Reset: state=IF immediately, asynchronously. Outputs decode from state, so they become IF values at once: IRWr=1, PCWr=mem_ready, all other enables 0.
- Reset asserted mid-MEM: MemWrite drops in the same cycle. The sw does not complete.
- Outputs are combinational from state, opcode and funct.
- Exceptions: PCWr in IF depends on mem_ready; PCWr in EXE depends on zero; instr_done depends on mem_ready in MEM.
- Cycle counts with mem_ready=1:
  - jal, jr, nop: 2
  - beq: 3
  - R-type, ori, lui, sw: 4
  - lw: 5
- Each cycle mem_ready=0 in IF or MEM adds one cycle.
- At most one instruction in flight. No overlap between instructions.

## Structure
- Shared package/header mc_defs:
  - state codes
  - opcode and funct constants
  - ALUCtrl, RegDst, RegSrc and nPC_sel encodings
- The datapath includes mc_defs too.
- Sub-module instr_decode: combinational opcode/funct to one-hot class (rtype_alu, ori, lui, lw, sw, beq, jal, jr, nop). The FSM consumes only the class.

## Test plan
- reset high with mem_ready=1, then released -> state=0, IRWr=1, PCWr=1, RegWrite=0, MemWrite=0. Next edge goes to state 1.
- addu (op 0, funct 100001), mem_ready=1 -> states 0,1,2,4. WB has RegWrite=1, RegDst=01, RegSrc=00. instr_done pulses once, in WB.
- lw with mem_ready low for 2 cycles in MEM -> states 0,1,2,3,3,3,4, i.e. 7 cycles. WB has RegSrc=01, RegDst=00.
- beq with zero=1, then again with zero=0 -> EXE PCWr=1 with nPC_sel=01 in the first case, PCWr=0 in the second. Both take 3 cycles.
- jal -> DCD asserts PCWr, RegWrite, RegDst=10, RegSrc=10, nPC_sel=10, and the next state is IF. Unknown opcode 111111 -> DCD has no enables and the next state is IF.
- sw with reset asserted during the second MEM cycle -> MemWrite=0 within that cycle and state=0.

Source files
------------

// File: rtl/mc_defs.sv
// ============================================================================
//  Module      : mc_defs (package)
//  Description : Shared definitions for the multi-cycle MIPS control path and
//                datapath: state codes, opcode/funct values, mux-select and
//                ALU encodings, and the one-hot instruction-class layout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_defs;

    // Controller state codes (3-bit state register).
    localparam logic [2:0] c_ST_IF  = 3'd0;
    localparam logic [2:0] c_ST_DCD = 3'd1;
    localparam logic [2:0] c_ST_EXE = 3'd2;
    localparam logic [2:0] c_ST_MEM = 3'd3;
    localparam logic [2:0] c_ST_WB  = 3'd4;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_JR   = 6'b001000;

    // ALUCtrl encodings.
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_OR  = 3'b010;
    localparam logic [2:0] c_ALU_LUI = 3'b011;

    // RegDst encodings.
    localparam logic [1:0] c_DST_RT = 2'b00;
    localparam logic [1:0] c_DST_RD = 2'b01;
    localparam logic [1:0] c_DST_RA = 2'b10;

    // RegSrc encodings.
    localparam logic [1:0] c_SRC_ALU = 2'b00;
    localparam logic [1:0] c_SRC_MEM = 2'b01;
    localparam logic [1:0] c_SRC_PC  = 2'b10;

    // nPC_sel encodings.
    localparam logic [1:0] c_NPC_SEQ = 2'b00;
    localparam logic [1:0] c_NPC_BR  = 2'b01;
    localparam logic [1:0] c_NPC_JMP = 2'b10;
    localparam logic [1:0] c_NPC_REG = 2'b11;

    // One-hot instruction class. The R-type ALU class is split into its add
    // and subtract members so the controller needs nothing but the class.
    localparam int c_CLS_W    = 10;
    localparam int c_CLS_ADDU = 0;
    localparam int c_CLS_SUBU = 1;
    localparam int c_CLS_ORI  = 2;
    localparam int c_CLS_LUI  = 3;
    localparam int c_CLS_LW   = 4;
    localparam int c_CLS_SW   = 5;
    localparam int c_CLS_BEQ  = 6;
    localparam int c_CLS_JAL  = 7;
    localparam int c_CLS_JR   = 8;
    localparam int c_CLS_NOP  = 9;

    typedef logic [c_CLS_W-1:0] instrClass_t;

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational decode of opcode/funct into a one-hot
//                instruction class. Any unsupported encoding maps to nop.
//  Ports       : i_opcode  - IR[31:26]
//                i_funct   - IR[5:0]
//                o_class   - one-hot class (exactly one bit set)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode
    import mc_defs::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output instrClass_t o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            c_OP_RTYPE: begin
                case (i_funct)
                    c_FN_ADDU: o_class[c_CLS_ADDU] = 1'b1;
                    c_FN_SUBU: o_class[c_CLS_SUBU] = 1'b1;
                    c_FN_JR:   o_class[c_CLS_JR]   = 1'b1;
                    default:   o_class[c_CLS_NOP]  = 1'b1;
                endcase
            end
            c_OP_ORI: o_class[c_CLS_ORI] = 1'b1;
            c_OP_LUI: o_class[c_CLS_LUI] = 1'b1;
            c_OP_LW:  o_class[c_CLS_LW]  = 1'b1;
            c_OP_SW:  o_class[c_CLS_SW]  = 1'b1;
            c_OP_BEQ: o_class[c_CLS_BEQ] = 1'b1;
            c_OP_JAL: o_class[c_CLS_JAL] = 1'b1;
            default:  o_class[c_CLS_NOP] = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle MIPS control FSM (IF/DCD/EXE/MEM/WB). Outputs
//                decode combinationally from the state register and the
//                decoded instruction class; the 3-bit state is the only
//                storage.
//  Ports       : clk, reset (async, active-high -> IF)
//                opcode, funct        - latched instruction fields
//                zero                 - ALU equal flag (EXE)
//                mem_ready            - shared memory port completes access
//                PCWr, IRWr, RegWrite, MemWrite - write enables
//                RegDst, RegSrc, ALUSrc, ExtOp, ALUCtrl, nPC_sel - selects
//                instr_done           - pulse on last cycle of instruction
//                state                - current state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mc_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] RegDst,
    output logic [1:0] RegSrc,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUCtrl,
    output logic [1:0] nPC_sel,
    output logic       instr_done,
    output logic [2:0] state
);

    logic [2:0]  r_state;
    logic [2:0]  w_nextState;
    instrClass_t w_class;
    logic        w_finishInDcd;

    instr_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class)
    );

    // jal, jr and nop complete entirely in DCD.
    assign w_finishInDcd = w_class[c_CLS_JAL] | w_class[c_CLS_JR] | w_class[c_CLS_NOP];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IF;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign state = r_state;

    always_comb begin
        w_nextState = c_ST_IF;
        PCWr        = 1'b0;
        IRWr        = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        RegDst      = c_DST_RT;
        RegSrc      = c_SRC_ALU;
        ALUSrc      = 1'b0;
        ExtOp       = 1'b0;
        ALUCtrl     = c_ALU_ADD;
        nPC_sel     = c_NPC_SEQ;
        instr_done  = 1'b0;

        // Selects stay constant from DCD to the end of the instruction so
        // the datapath sees stable inputs. IR is not valid yet during IF.
        if (r_state != c_ST_IF) begin
            if (w_class[c_CLS_ADDU]) begin
                RegDst = c_DST_RD;
            end
            if (w_class[c_CLS_SUBU]) begin
                ALUCtrl = c_ALU_SUB;
                RegDst  = c_DST_RD;
            end
            if (w_class[c_CLS_ORI]) begin
                ALUCtrl = c_ALU_OR;
                ALUSrc  = 1'b1;
            end
            if (w_class[c_CLS_LUI]) begin
                ALUCtrl = c_ALU_LUI;
                ALUSrc  = 1'b1;
            end
            if (w_class[c_CLS_LW] | w_class[c_CLS_SW]) begin
                ALUSrc = 1'b1;
                ExtOp  = 1'b1;
            end
            if (w_class[c_CLS_LW]) begin
                RegSrc = c_SRC_MEM;
            end
            if (w_class[c_CLS_BEQ]) begin
                ALUCtrl = c_ALU_SUB;
                ExtOp   = 1'b1;
                nPC_sel = c_NPC_BR;
            end
            if (w_class[c_CLS_JAL]) begin
                RegDst  = c_DST_RA;
                RegSrc  = c_SRC_PC;
                nPC_sel = c_NPC_JMP;
            end
            if (w_class[c_CLS_JR]) begin
                nPC_sel = c_NPC_REG;
            end
        end

        case (r_state)
            c_ST_IF: begin
                IRWr        = 1'b1;
                PCWr        = mem_ready;
                w_nextState = mem_ready ? c_ST_DCD : c_ST_IF;
            end
            c_ST_DCD: begin
                PCWr        = w_class[c_CLS_JAL] | w_class[c_CLS_JR];
                RegWrite    = w_class[c_CLS_JAL];
                instr_done  = w_finishInDcd;
                w_nextState = w_finishInDcd ? c_ST_IF : c_ST_EXE;
            end
            c_ST_EXE: begin
                PCWr       = w_class[c_CLS_BEQ] & zero;
                instr_done = w_class[c_CLS_BEQ];
                if (w_class[c_CLS_BEQ]) begin
                    w_nextState = c_ST_IF;
                end else if (w_class[c_CLS_LW] | w_class[c_CLS_SW]) begin
                    w_nextState = c_ST_MEM;
                end else begin
                    w_nextState = c_ST_WB;
                end
            end
            c_ST_MEM: begin
                MemWrite   = w_class[c_CLS_SW];
                instr_done = w_class[c_CLS_SW] & mem_ready;
                if (!mem_ready) begin
                    w_nextState = c_ST_MEM;
                end else if (w_class[c_CLS_SW]) begin
                    w_nextState = c_ST_IF;
                end else begin
                    w_nextState = c_ST_WB;
                end
            end
            c_ST_WB: begin
                RegWrite    = 1'b1;
                instr_done  = 1'b1;
                w_nextState = c_ST_IF;
            end
            default: begin
                w_nextState = c_ST_IF;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Each instruction's
//                expected state walk, enables, selects and cycle count are
//                derived from the instruction's rules, then compared cycle by
//                cycle against the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrc, ExtOp, instr_done;
    logic [1:0] RegDst, RegSrc, nPC_sel;
    logic [2:0] ALUCtrl, state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .RegSrc     (RegSrc),
        .ALUSrc     (ALUSrc),
        .ExtOp      (ExtOp),
        .ALUCtrl    (ALUCtrl),
        .nPC_sel    (nPC_sel),
        .instr_done (instr_done),
        .state      (state)
    );

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
    localparam int K_SW = 5, K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9;
    localparam int S_IF = 0, S_DCD = 1, S_EXE = 2, S_MEM = 3, S_WB = 4;

    int nAssert = 0;
    int nFail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive opcode/funct for an instruction kind; nop picks one of several
    // unsupported encodings.
    task automatic setInstr(input int kind);
        funct = 6'($urandom);
        case (kind)
            K_ADDU: begin opcode = 6'b000000; funct = 6'b100001; end
            K_SUBU: begin opcode = 6'b000000; funct = 6'b100011; end
            K_JR:   begin opcode = 6'b000000; funct = 6'b001000; end
            K_ORI:  opcode = 6'b001101;
            K_LUI:  opcode = 6'b001111;
            K_LW:   opcode = 6'b100011;
            K_SW:   opcode = 6'b101011;
            K_BEQ:  opcode = 6'b000100;
            K_JAL:  opcode = 6'b000011;
            default: begin
                case ($urandom_range(0, 3))
                    0:       opcode = 6'b111111;
                    1:       opcode = 6'b000010;
                    2:       opcode = 6'b001000;
                    default: begin opcode = 6'b000000; funct = 6'b100000; end
                endcase
            end
        endcase
    endtask

    // Run one instruction starting in IF. ifStalls / memStalls give the
    // number of mem_ready=0 cycles in IF and MEM.
    task automatic runInstr(input int kind, input int ifStalls, input int memStalls,
                            input logic z, input string tag);
        int  expSt[$];
        int  expCycles;
        int  cyc;
        int  ifSeen;
        int  memSeen;
        int  st;
        bit  done;
        bit  aluKind;
        logic [2:0] expAlu;
        logic expSrc;

        expSt = {};
        repeat (ifStalls + 1) expSt.push_back(S_IF);
        expSt.push_back(S_DCD);
        if (kind == K_BEQ) begin
            expSt.push_back(S_EXE);
        end else if (kind inside {K_ADDU, K_SUBU, K_ORI, K_LUI}) begin
            expSt.push_back(S_EXE);
            expSt.push_back(S_WB);
        end else if (kind == K_SW || kind == K_LW) begin
            expSt.push_back(S_EXE);
            repeat (memStalls + 1) expSt.push_back(S_MEM);
            if (kind == K_LW) expSt.push_back(S_WB);
        end

        // Cycle budget from the timing table, plus stalls.
        case (kind)
            K_JAL, K_JR, K_NOP: expCycles = 2;
            K_BEQ:              expCycles = 3;
            K_LW:               expCycles = 5;
            default:            expCycles = 4;
        endcase
        expCycles += ifStalls;
        if (kind == K_LW || kind == K_SW) expCycles += memStalls;

        aluKind = 1'b1;
        expSrc  = 1'b0;
        case (kind)
            K_ADDU:       expAlu = 3'b000;
            K_SUBU:       expAlu = 3'b001;
            K_BEQ:        expAlu = 3'b001;
            K_ORI:  begin expAlu = 3'b010; expSrc = 1'b1; end
            K_LUI:  begin expAlu = 3'b011; expSrc = 1'b1; end
            K_LW, K_SW: begin expAlu = 3'b000; expSrc = 1'b1; end
            default: begin expAlu = 3'b000; aluKind = 1'b0; end
        endcase

        setInstr(kind);
        zero    = z;
        cyc     = 0;
        ifSeen  = 0;
        memSeen = 0;
        done    = 1'b0;
        while (!done && cyc < 20) begin
            st = (cyc < expSt.size()) ? expSt[cyc] : 7;
            if (st == S_IF) begin
                mem_ready = (ifSeen < ifStalls) ? 1'b0 : 1'b1;
                ifSeen++;
            end else if (st == S_MEM) begin
                mem_ready = (memSeen < memStalls) ? 1'b0 : 1'b1;
                memSeen++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk($sformatf("%s.c%0d.state", tag, cyc), 32'(state), st);
            chk($sformatf("%s.c%0d.IRWr", tag, cyc), 32'(IRWr), 32'(st == S_IF));
            chk($sformatf("%s.c%0d.PCWr", tag, cyc), 32'(PCWr),
                32'((st == S_IF && mem_ready) ||
                    (st == S_DCD && (kind == K_JAL || kind == K_JR)) ||
                    (st == S_EXE && kind == K_BEQ && z)));
            chk($sformatf("%s.c%0d.RegWrite", tag, cyc), 32'(RegWrite),
                32'((st == S_DCD && kind == K_JAL) || st == S_WB));
            chk($sformatf("%s.c%0d.MemWrite", tag, cyc), 32'(MemWrite),
                32'(st == S_MEM && kind == K_SW));
            chk($sformatf("%s.c%0d.instr_done", tag, cyc), 32'(instr_done),
                32'(cyc == expSt.size() - 1));
            if (st == S_IF)
                chk($sformatf("%s.c%0d.nPC_sel", tag, cyc), 32'(nPC_sel), 0);
            if (st != S_IF && aluKind) begin
                chk($sformatf("%s.c%0d.ALUCtrl", tag, cyc), 32'(ALUCtrl), 32'(expAlu));
                chk($sformatf("%s.c%0d.ALUSrc", tag, cyc), 32'(ALUSrc), 32'(expSrc));
                if (kind inside {K_BEQ, K_LW, K_SW, K_ORI, K_LUI})
                    chk($sformatf("%s.c%0d.ExtOp", tag, cyc), 32'(ExtOp),
                        32'(kind inside {K_BEQ, K_LW, K_SW}));
            end
            if (st == S_WB) begin
                chk($sformatf("%s.c%0d.RegDst", tag, cyc), 32'(RegDst),
                    (kind == K_ADDU || kind == K_SUBU) ? 1 : 0);
                chk($sformatf("%s.c%0d.RegSrc", tag, cyc), 32'(RegSrc),
                    (kind == K_LW) ? 1 : 0);
            end
            if (st == S_DCD && kind == K_JAL) begin
                chk($sformatf("%s.c%0d.RegDst", tag, cyc), 32'(RegDst), 2);
                chk($sformatf("%s.c%0d.RegSrc", tag, cyc), 32'(RegSrc), 2);
                chk($sformatf("%s.c%0d.nPC_sel", tag, cyc), 32'(nPC_sel), 2);
            end
            if (st == S_DCD && kind == K_JR)
                chk($sformatf("%s.c%0d.nPC_sel", tag, cyc), 32'(nPC_sel), 3);
            if (st == S_EXE && kind == K_BEQ)
                chk($sformatf("%s.c%0d.nPC_sel", tag, cyc), 32'(nPC_sel), 1);
            done = instr_done;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("%s.cycles", tag), cyc, expCycles);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = 6'b000000;
        funct     = 6'b000000;

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst.state", 32'(state), 0);
        chk("rst.IRWr", 32'(IRWr), 1);
        chk("rst.PCWr", 32'(PCWr), 1);
        chk("rst.RegWrite", 32'(RegWrite), 0);
        chk("rst.MemWrite", 32'(MemWrite), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.next_state", 32'(state), 1);
        chk("rst.nop_done", 32'(instr_done), 1);
        chk("rst.nop_noenable", 32'({PCWr, IRWr, RegWrite, MemWrite}), 0);
        @(posedge clk);
        #1;
        chk("rst.back_to_if", 32'(state), 0);

        // Directed cases.
        runInstr(K_ADDU, 0, 0, 1'b0, "addu");
        runInstr(K_LW,   0, 2, 1'b0, "lw_stall");
        runInstr(K_BEQ,  0, 0, 1'b1, "beq_taken");
        runInstr(K_BEQ,  0, 0, 1'b0, "beq_not");
        runInstr(K_JAL,  0, 0, 1'b0, "jal");
        runInstr(K_NOP,  1, 0, 1'b0, "nop");
        runInstr(K_SUBU, 2, 0, 1'b0, "subu_ifstall");
        runInstr(K_SW,   0, 1, 1'b0, "sw");
        runInstr(K_JR,   0, 0, 1'b0, "jr");
        runInstr(K_ORI,  0, 0, 1'b0, "ori");
        runInstr(K_LUI,  0, 0, 1'b0, "lui");

        // sw interrupted by reset in its second MEM cycle.
        setInstr(K_SW);
        mem_ready = 1'b1;
        @(posedge clk); #1;          // DCD
        @(posedge clk); #1;          // EXE
        mem_ready = 1'b0;
        @(posedge clk); #1;          // MEM, first cycle
        @(posedge clk); #1;          // MEM, second cycle
        @(negedge clk);
        chk("swrst.pre_state", 32'(state), 3);
        chk("swrst.pre_MemWrite", 32'(MemWrite), 1);
        reset = 1'b1;
        #1;
        chk("swrst.MemWrite", 32'(MemWrite), 0);
        chk("swrst.state", 32'(state), 0);
        chk("swrst.IRWr", 32'(IRWr), 1);
        chk("swrst.instr_done", 32'(instr_done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("swrst.held_if", 32'(state), 0);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            runInstr(int'($urandom_range(0, 9)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

`default_nettype wire
